// File: rtl/multicycle_cpu_if.sv
// Unified instruction/data memory port of the multicycle core.
// The core drives the request side; memory answers with rdata/ack.
interface multicycle_cpu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;
    logic              mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_rdata_i,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_rdata_i,
        output mem_ack_i
    );
endinterface

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB with a HALT trap
// on undefined encodings, sharing one request/ack memory port.
module multicycle_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_cpu_if.master  mem,
    output logic [ADDR_W-1:0] pc_o,
    output logic              retire_o,
    output logic              halt_o
);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [3:0] {
        K_ALU, K_ADDI, K_SLTI, K_LW, K_SW,
        K_BEQ, K_BNE, K_J, K_JAL, K_JR
    } kind_t;

    state_t            state, state_n;
    kind_t             kind;
    logic              legal;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir, a, b, alu_q, mdr, alu_r, imm;
    logic [31:0]       rf [32];
    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, shamt;
    logic              req_raw, ack_hit;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign shamt = ir[10:6];
    assign funct = ir[5:0];
    assign imm   = {{16{ir[15]}}, ir[15:0]};

    always_comb begin
        kind  = K_ALU;
        legal = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22, 6'h24,
                    6'h25, 6'h2A, 6'h00: kind = K_ALU;
                    6'h08:               kind = K_JR;
                    default:             legal = 1'b0;
                endcase
            end
            6'h08:   kind = K_ADDI;
            6'h0A:   kind = K_SLTI;
            6'h23:   kind = K_LW;
            6'h2B:   kind = K_SW;
            6'h04:   kind = K_BEQ;
            6'h05:   kind = K_BNE;
            6'h02:   kind = K_J;
            6'h03:   kind = K_JAL;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_r = '0;
        case (kind)
            K_ALU: begin
                case (funct)
                    6'h20:   alu_r = a + b;
                    6'h22:   alu_r = a - b;
                    6'h24:   alu_r = a & b;
                    6'h25:   alu_r = a | b;
                    6'h2A:   alu_r = {31'b0, $signed(a) < $signed(b)};
                    6'h00:   alu_r = b << shamt;
                    default: alu_r = '0;
                endcase
            end
            K_ADDI, K_LW, K_SW: alu_r = a + imm;
            K_SLTI:  alu_r = {31'b0, $signed(a) < $signed(imm)};
            default: alu_r = '0;
        endcase
    end

    // Reset gates the request so a pending transaction drops at once.
    assign req_raw       = (state == FETCH) || (state == MEM);
    assign mem.mem_req_o = req_raw && !rst_i;
    assign ack_hit       = mem.mem_req_o && mem.mem_ack_i;

    always_comb begin
        state_n         = state;
        mem.mem_we_o    = 1'b0;
        mem.mem_addr_o  = pc;
        mem.mem_wdata_o = b;
        retire_o        = 1'b0;
        case (state)
            FETCH: if (ack_hit) state_n = DECODE;
            DECODE: state_n = legal ? EXEC : HALT;
            EXEC: begin
                case (kind)
                    K_LW, K_SW: state_n = MEM;
                    K_BEQ, K_BNE, K_J, K_JAL, K_JR: begin
                        state_n  = FETCH;
                        retire_o = 1'b1;
                    end
                    default: state_n = WB;
                endcase
            end
            MEM: begin
                mem.mem_we_o   = (kind == K_SW);
                mem.mem_addr_o = {alu_q[ADDR_W-1:2], 2'b00};
                if (ack_hit) begin
                    state_n  = (kind == K_SW) ? FETCH : WB;
                    retire_o = (kind == K_SW);
                end
            end
            WB: begin
                state_n  = FETCH;
                retire_o = 1'b1;
            end
            HALT:    state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (state == EXEC && kind == K_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = 32'(pc);
        end else if (state == WB) begin
            rf_we    = 1'b1;
            rf_waddr = (kind == K_ALU) ? rd : rt;
            rf_wdata = (kind == K_LW) ? mdr : alu_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= FETCH;
            pc    <= ADDR_W'(RESET_PC);
            ir    <= '0;
            a     <= '0;
            b     <= '0;
            alu_q <= '0;
            mdr   <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            state <= state_n;
            case (state)
                FETCH: begin
                    if (ack_hit) begin
                        ir <= mem.mem_rdata_i;
                        pc <= pc + ADDR_W'(4);
                    end
                end
                DECODE: begin
                    a <= rf[rs];
                    b <= rf[rt];
                end
                EXEC: begin
                    alu_q <= alu_r;
                    // pc already holds PC+4 here, the base of every target.
                    case (kind)
                        K_BEQ: if (a == b)
                            pc <= pc + ADDR_W'({imm[29:0], 2'b00});
                        K_BNE: if (a != b)
                            pc <= pc + ADDR_W'({imm[29:0], 2'b00});
                        K_J, K_JAL:
                            pc <= ADDR_W'({4'(32'(pc) >> 28), ir[25:0], 2'b00});
                        K_JR:    pc <= a[ADDR_W-1:0];
                        default: pc <= pc;
                    endcase
                end
                MEM: if (ack_hit && kind == K_LW) mdr <= mem.mem_rdata_i;
                default: ;
            endcase
            if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
        end
    end

    assign pc_o   = pc;
    assign halt_o = (state == HALT);

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: directed programs plus random programs, each
// scored bus-transaction by bus-transaction against an instruction-level model.
module tb_multicycle_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        retire, halt;

    multicycle_cpu_if #(.ADDR_W(32)) bus ();

    multicycle_cpu #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (32)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .mem     (bus),
        .pc_o    (pc),
        .retire_o(retire),
        .halt_o  (halt)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] NOBRK  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic [31:0] mem [256];
    logic [31:0] mm  [256];
    logic [31:0] r   [32];
    logic [31:0] ipc;
    bit          ihalt;
    int          iss_ret;
    txn_t        exp_q[$];
    int          rc[$];
    logic [31:0] rq[$], wa[$], wd[$];
    int          nchk = 0, npass = 0, nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int fn, input int s,
                                          input int t, input int d,
                                          input int sh);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int o, input int s,
                                          input int t, input int im);
        return {6'(o), 5'(s), 5'(t), 16'(im)};
    endfunction

    function automatic logic [31:0] enc_j(input int o, input int tg);
        return {6'(o), 26'(tg)};
    endfunction

    task automatic put(input logic [31:0] ad, input logic [31:0] w);
        mem[ad[9:2]] = w;
        mm[ad[9:2]]  = w;
    endtask

    task automatic clr();
        for (int i = 0; i < 256; i++) begin
            mem[i] = HALT_W;
            mm[i]  = HALT_W;
        end
    endtask

    task automatic setr(input int d, input logic [31:0] v);
        if (d != 0) r[d] = v;
    endtask

    // Executes one whole instruction architecturally and queues the bus
    // transactions it must produce.
    task automatic iss_step();
        logic [31:0] w, sx, npc, ea, link;
        int          o, fn, s, t, d, sh;
        bit          ok;
        w    = mm[ipc[9:2]];
        exp_q.push_back({1'b0, ipc, 32'h0});
        o    = int'(w[31:26]);
        s    = int'(w[25:21]);
        t    = int'(w[20:16]);
        d    = int'(w[15:11]);
        sh   = int'(w[10:6]);
        fn   = int'(w[5:0]);
        sx   = {{16{w[15]}}, w[15:0]};
        npc  = ipc + 32'd4;
        link = ipc + 32'd4;
        ea   = (r[s] + sx) & ~32'h3;
        ok   = 1'b1;
        if (o == 0) begin
            case (fn)
                'h20: setr(d, r[s] + r[t]);
                'h22: setr(d, r[s] - r[t]);
                'h24: setr(d, r[s] & r[t]);
                'h25: setr(d, r[s] | r[t]);
                'h2A: setr(d, ($signed(r[s]) < $signed(r[t])) ? 1 : 0);
                'h00: setr(d, r[t] << sh);
                'h08: npc = r[s];
                default: ok = 1'b0;
            endcase
        end else begin
            case (o)
                'h08: setr(t, r[s] + sx);
                'h0A: setr(t, ($signed(r[s]) < $signed(sx)) ? 1 : 0);
                'h23: begin
                    exp_q.push_back({1'b0, ea, 32'h0});
                    setr(t, mm[ea[9:2]]);
                end
                'h2B: begin
                    exp_q.push_back({1'b1, ea, r[t]});
                    mm[ea[9:2]] = r[t];
                end
                'h04: if (r[s] == r[t]) npc = npc + (sx << 2);
                'h05: if (r[s] != r[t]) npc = npc + (sx << 2);
                'h02: npc = {npc[31:28], w[25:0], 2'b00};
                'h03: begin
                    npc = {npc[31:28], w[25:0], 2'b00};
                    setr(31, link);
                end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) ihalt = 1'b1;
        else iss_ret++;
        ipc = npc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = $urandom;
        #1;
        check("rst_req", {31'b0, bus.mem_req_o}, 0);
        check("rst_we", {31'b0, bus.mem_we_o}, 0);
        check("rst_retire", {31'b0, retire}, 0);
        check("rst_halt", {31'b0, halt}, 0);
        check("rst_pc", pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) r[i] = '0;
        ipc     = 32'h0;
        ihalt   = 1'b0;
        iss_ret = 0;
        exp_q.delete();
        rc.delete();
        rq.delete();
        wa.delete();
        wd.delete();
        bus.mem_ack_i = 1'b0;
        rst = 1'b0;
    endtask

    // mode: fixed wait states per transaction, or -1 for random 0..2.
    task automatic run(input int mode, input int maxcyc, input bit to_halt,
                       input logic [31:0] brk);
        int          waits;
        bit          pending, wr;
        logic        hwe;
        logic [31:0] haddr, hwd, waddr, wdat;
        txn_t        t;
        waits   = 0;
        pending = 1'b0;
        hwe     = 1'b0;
        haddr   = '0;
        hwd     = '0;
        waddr   = '0;
        wdat    = '0;
        for (int c = 1; c <= maxcyc; c++) begin
            #1;
            wr = 1'b0;
            if (bus.mem_req_o && !bus.mem_we_o && bus.mem_addr_o === brk)
                break;
            if (bus.mem_req_o) begin
                if (!pending) begin
                    pending = 1'b1;
                    waits   = (mode < 0) ? int'($urandom_range(0, 2)) : mode;
                    hwe     = bus.mem_we_o;
                    haddr   = bus.mem_addr_o;
                    hwd     = bus.mem_wdata_o;
                end else begin
                    check("hold_we", {31'b0, bus.mem_we_o}, {31'b0, hwe});
                    check("hold_addr", bus.mem_addr_o, haddr);
                    check("hold_wdata", bus.mem_wdata_o, hwd);
                end
                if (waits == 0) begin
                    pending         = 1'b0;
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = mem[bus.mem_addr_o[9:2]];
                    if (exp_q.size() == 0 && !ihalt) iss_step();
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", {31'b0, bus.mem_req_o}, 0);
                    end else begin
                        t = exp_q.pop_front();
                        check("bus_we", {31'b0, bus.mem_we_o}, {31'b0, t.we});
                        check("bus_addr", bus.mem_addr_o, t.addr);
                        if (t.we) check("bus_wdata", bus.mem_wdata_o, t.wdata);
                    end
                    if (bus.mem_we_o) begin
                        wr    = 1'b1;
                        waddr = bus.mem_addr_o;
                        wdat  = bus.mem_wdata_o;
                    end else begin
                        rq.push_back(bus.mem_addr_o);
                    end
                end else begin
                    waits--;
                    bus.mem_ack_i   = 1'b0;
                    bus.mem_rdata_i = $urandom;
                end
            end else begin
                if (pending) check("req_dropped", {31'b0, bus.mem_req_o}, 1);
                pending         = 1'b0;
                bus.mem_ack_i   = 1'($urandom_range(0, 1));
                bus.mem_rdata_i = $urandom;
            end
            #1;
            if (retire) rc.push_back(c);
            @(posedge clk);
            if (wr) begin
                mem[waddr[9:2]] = wdat;
                wa.push_back(waddr);
                wd.push_back(wdat);
            end
            @(negedge clk);
            if (to_halt && halt) break;
        end
        bus.mem_ack_i = 1'b0;
        if (to_halt) begin
            check("halt_reached", {31'b0, halt}, 1);
            check("halt_pc", pc, ipc);
            check("retire_count", rc.size(), iss_ret);
        end
    endtask

    task automatic gen_prog(input int n);
        int k, s, t, d;
        for (int i = 0; i < n; i++) begin
            k = int'($urandom_range(0, 11));
            s = int'($urandom_range(0, 7));
            t = int'($urandom_range(1, 7));
            d = int'($urandom_range(1, 7));
            case (k)
                0: put(i * 4, enc_i('h08, s, t, int'($urandom_range(0, 65535))));
                1: put(i * 4, enc_r('h20, s, t, d, 0));
                2: put(i * 4, enc_r('h22, s, t, d, 0));
                3: put(i * 4, enc_r('h24, s, t, d, 0));
                4: put(i * 4, enc_r('h25, s, t, d, 0));
                5: put(i * 4, enc_r('h2A, s, t, d, 0));
                6: put(i * 4, enc_r('h00, 0, s, d, int'($urandom_range(0, 31))));
                7: put(i * 4, enc_i('h0A, s, t, int'($urandom_range(0, 65535))));
                8: put(i * 4, enc_i('h23, 0, t, 'h200 + int'($urandom_range(0, 63))));
                9: put(i * 4, enc_i('h2B, 0, s, 'h200 + int'($urandom_range(0, 63))));
                10: put(i * 4, enc_i('h04, s, t, int'($urandom_range(0, 3))));
                default: put(i * 4, enc_i('h05, s, t, int'($urandom_range(0, 3))));
            endcase
        end
        for (int j = 1; j < 8; j++) put((n + j - 1) * 4, enc_i('h2B, 0, j, 'h300 + 4 * j));
        for (int a = 'h200; a < 'h300; a += 4) put(a, $urandom);
    endtask

    initial begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        #2;

        // ALU sequence, zero-wait: retires at 4, 8, 12.
        clr();
        put('h00, enc_i('h08, 0, 1, 5));
        put('h04, enc_i('h08, 0, 2, -3));
        put('h08, enc_r('h20, 1, 2, 3, 0));
        put('h0C, enc_i('h2B, 0, 3, 'h100));
        do_reset();
        run(0, 200, 1'b1, NOBRK);
        check("alu_ret0", rc[0], 4);
        check("alu_ret1", rc[1], 8);
        check("alu_ret2", rc[2], 12);
        check("alu_sum", wd[0], 32'd2);

        // Store/load through three wait states.
        clr();
        put('h00, enc_i('h08, 0, 3, 2));
        put('h04, 32'h0);
        put('h08, enc_i('h2B, 0, 3, 8));
        put('h0C, enc_i('h23, 0, 4, 8));
        put('h10, enc_i('h2B, 0, 4, 'h104));
        do_reset();
        run(3, 400, 1'b1, NOBRK);
        check("sw_addr", wa[0], 32'h8);
        check("sw_data", wd[0], 32'h2);
        check("lw_data", wd[1], 32'h2);

        // beq self-loop at 0x10 every three cycles.
        clr();
        for (int i = 0; i < 4; i++) put(i * 4, 32'h0);
        put('h10, enc_i('h04, 0, 0, -1));
        do_reset();
        run(0, 25, 1'b0, NOBRK);
        check("beq_ret4", rc[4], 19);
        check("beq_ret5", rc[5], 22);
        check("beq_ret6", rc[6], 25);
        check("beq_fetch", rq[6], 32'h10);

        // bne not taken falls through to the halt at 0x14.
        clr();
        put('h00, enc_j('h02, 'h4));
        put('h10, enc_i('h05, 0, 0, 5));
        do_reset();
        run(0, 100, 1'b1, NOBRK);
        check("bne_pc", pc, 32'h18);
        check("bne_fetch", rq[2], 32'h14);

        // jal / jr round trip.
        clr();
        put('h000, enc_j('h02, 'h8));
        put('h020, enc_j('h03, 'h40));
        put('h100, enc_r('h08, 31, 0, 0, 0));
        put('h024, enc_i('h2B, 0, 31, 'h108));
        do_reset();
        run(-1, 300, 1'b1, NOBRK);
        check("jal_f1", rq[1], 32'h20);
        check("jal_f2", rq[2], 32'h100);
        check("jal_f3", rq[3], 32'h24);
        check("jal_link", wd[0], 32'h24);

        // Undefined opcode halts; reset resumes fetching.
        clr();
        put('h0, 32'h0);
        put('h4, 32'h0);
        do_reset();
        run(0, 100, 1'b1, NOBRK);
        check("undef_pc", pc, 32'hC);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack_i = 1'b1;
            #1;
            check("halt_noreq", {31'b0, bus.mem_req_o}, 0);
            check("halt_ret", {31'b0, retire}, 0);
            @(negedge clk);
        end
        do_reset();
        run(0, 1, 1'b0, NOBRK);
        check("resume_fetch", rq.size(), 1);

        // Reset while a lw is waiting on memory.
        clr();
        put('h00, enc_i('h08, 0, 1, 7));
        put('h04, enc_i('h2B, 0, 1, 'h80));
        put('h08, enc_i('h23, 0, 5, 'h80));
        put('h0C, enc_i('h2B, 0, 5, 'h84));
        do_reset();
        run(1, 200, 1'b0, 32'h80);
        check("lw_pending", {31'b0, bus.mem_req_o}, 1);
        bus.mem_ack_i = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_drop", {31'b0, bus.mem_req_o}, 0);
        clr();
        put('h00, enc_i('h2B, 0, 5, 'h88));
        do_reset();
        run(0, 100, 1'b1, NOBRK);
        check("lw_abandoned", wd[0], 32'h0);

        // Random programs with random wait states.
        for (int p = 0; p < 4; p++) begin
            clr();
            gen_prog(40);
            do_reset();
            run(-1, 4000, 1'b1, NOBRK);
            check("rand_stores", wa.size() >= 7 ? 1 : 0, 1);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
